// File: rtl/gear_input_pkg.sv
// ---------------------------------------------------------------------------
// gear_input_pkg
// Shared constants for the gearbox button front-end: channel indices,
// default parameter values, the auto-repeat state type and a counter-width
// helper used by the prescaler, debounce and repeat counters.
// ---------------------------------------------------------------------------
package gear_input_pkg;

    // Channel indices into the per-button vectors.
    localparam int CH_UP    = 0;
    localparam int CH_DOWN  = 1;
    localparam int CH_BRAKE = 2;
    localparam int NUM_CH   = 3;

    // Default parameter values.
    localparam int DEF_SAMPLE_DIV   = 1000;
    localparam int DEF_DEBOUNCE_N   = 4;
    localparam int DEF_REPEAT_DELAY = 50;
    localparam int DEF_REPEAT_RATE  = 20;

    // Auto-repeat phase: waiting for the first repeat, or repeating.
    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_RATE
    } rpt_state_e;

    // Bits needed for a counter that runs 0..n_states-1 (never less than 1).
    function automatic int cnt_width(input int n_states);
        return (n_states <= 2) ? 1 : $clog2(n_states);
    endfunction

endpackage : gear_input_pkg

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One button channel: two-flop synchroniser, saturating agreement counter
// and the debounced 'stable' level.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   btn_raw     in   raw asynchronous button pin
//   sample_stb  in   one-cycle debounce sample strobe
//   stable      out  registered debounced level
//   stable_nxt  out  value 'stable' takes at the next edge; lets the parent
//                    register its edge-derived outputs on the same edge
// ---------------------------------------------------------------------------
module debounce_channel
    import gear_input_pkg::*;
#(
    parameter int DEBOUNCE_N = DEF_DEBOUNCE_N
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic sample_stb,
    output logic stable,
    output logic stable_nxt
);

    // cnt only ever holds 0..DEBOUNCE_N-1: reaching DEBOUNCE_N toggles
    // 'stable' and clears, so the counter can never wrap.
    localparam int             CW       = cnt_width(DEBOUNCE_N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_N - 1);

    logic          sync_q1, sync_q2;
    logic [CW-1:0] cnt, cnt_nxt;

    // NOTE: every output of an always_comb gets a default on entry, so no
    // path through the block leaves a value unassigned and infers a latch.
    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = cnt;
        if (sample_stb) begin
            if (sync_q2 == stable) begin
                cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
                stable_nxt = ~stable;
                cnt_nxt    = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            stable  <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            cnt     <= cnt_nxt;
            stable  <= stable_nxt;
        end
    end

endmodule : debounce_channel

// File: rtl/gear_input_conditioner.sv
// ---------------------------------------------------------------------------
// gear_input_conditioner
// Button front-end for the gearbox shifter: synchronises and debounces the
// shift-up, shift-down and brake buttons and turns debounced rising edges
// into one-cycle shift requests for the gearbox FSM.
//
// Configuration macro: GEAR_AUTOREPEAT_EN
//   defined   - a held, still-permitted shift button re-fires after
//               REPEAT_DELAY strobes, then every REPEAT_RATE strobes.
//   undefined - exactly one pulse per press.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ena          in   block enable; 0 freezes sampling and forces pulses low
//   btn_up       in   raw shift-up button
//   btn_down     in   raw shift-down button
//   btn_brake    in   raw brake button
//   up_pulse     out  one-cycle shift-up request
//   down_pulse   out  one-cycle shift-down request
//   brake_level  out  debounced brake level, registered
// ---------------------------------------------------------------------------
module gear_input_conditioner
    import gear_input_pkg::*;
#(
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int DEBOUNCE_N   = DEF_DEBOUNCE_N,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_brake,
    output logic up_pulse,
    output logic down_pulse,
    output logic brake_level
);

    // Repeat parameters are validated even when auto-repeat is compiled
    // out, so enabling it later cannot silently pick up bad values.
    if (SAMPLE_DIV < 2) begin : g_bad_sample_div
        $error("SAMPLE_DIV must be >= 2");
    end
    if (DEBOUNCE_N < 1) begin : g_bad_debounce_n
        $error("DEBOUNCE_N must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    // ------------------------------------------------------------------
    // Prescaler: sample_stb marks the last count of each period.
    // ------------------------------------------------------------------
    localparam int            PW         = cnt_width(SAMPLE_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);

    logic [PW-1:0] presc;
    logic          sample_stb;

    assign sample_stb = ena && (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (ena) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-button synchroniser and debounce.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] btn_raw, stable, stable_nxt;

    assign btn_raw[CH_UP]    = btn_up;
    assign btn_raw[CH_DOWN]  = btn_down;
    assign btn_raw[CH_BRAKE] = btn_brake;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_N (DEBOUNCE_N)
        ) u_debounce (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_raw    (btn_raw[ch]),
            .sample_stb (sample_stb),
            .stable     (stable[ch]),
            .stable_nxt (stable_nxt[ch])
        );
    end

    // ------------------------------------------------------------------
    // Request rules, evaluated on the post-update debounced levels.
    // A simultaneous up/down rise blocks both, and the two permits are
    // mutually exclusive, so the pulses can never coincide.
    // ------------------------------------------------------------------
    logic up_rise, down_rise, up_ok, down_ok;
    logic [1:0] rpt_hit;   // [0] up, [1] down

    assign up_rise   = stable_nxt[CH_UP]   & ~stable[CH_UP];
    assign down_rise = stable_nxt[CH_DOWN] & ~stable[CH_DOWN];
    assign up_ok     = stable_nxt[CH_UP]   & ~stable_nxt[CH_DOWN] & ~stable_nxt[CH_BRAKE];
    assign down_ok   = stable_nxt[CH_DOWN] & ~stable_nxt[CH_UP];

`ifdef GEAR_AUTOREPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat: armed only by a real initial pulse, counts strobes while
    // the request stays permitted, and drops back to idle otherwise.
    // ------------------------------------------------------------------
    localparam int            RPT_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            RW         = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    rpt_state_e    rpt_state [2];
    logic [RW-1:0] rpt_cnt   [2];
    logic [1:0]    rpt_ok, rpt_start;

    assign rpt_ok    = {down_ok, up_ok};
    assign rpt_start = {down_rise & down_ok, up_rise & up_ok};

    always_comb begin
        rpt_hit = '0;
        for (int i = 0; i < 2; i++) begin
            rpt_hit[i] = sample_stb && rpt_ok[i] && !rpt_start[i] &&
                         (((rpt_state[i] == RPT_DELAY) && (rpt_cnt[i] == DELAY_LAST)) ||
                          ((rpt_state[i] == RPT_RATE)  && (rpt_cnt[i] == RATE_LAST)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rpt_state[i] <= RPT_IDLE;
                rpt_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!rpt_ok[i]) begin
                    rpt_state[i] <= RPT_IDLE;
                    rpt_cnt[i]   <= '0;
                end else if (sample_stb) begin
                    if (rpt_start[i]) begin
                        rpt_state[i] <= RPT_DELAY;
                        rpt_cnt[i]   <= '0;
                    end else if (rpt_hit[i]) begin
                        rpt_state[i] <= RPT_RATE;
                        rpt_cnt[i]   <= '0;
                    end else if (rpt_state[i] != RPT_IDLE) begin
                        rpt_cnt[i]   <= rpt_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign rpt_hit = 2'b00;
`endif

    // ------------------------------------------------------------------
    // Registered outputs: pulses land 1 clk after the deciding strobe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_pulse    <= 1'b0;
            down_pulse  <= 1'b0;
            brake_level <= 1'b0;
        end else begin
            up_pulse    <= ena & ((up_rise & up_ok) | rpt_hit[0]);
            down_pulse  <= ena & ((down_rise & down_ok) | rpt_hit[1]);
            brake_level <= stable[CH_BRAKE];
        end
    end

endmodule : gear_input_conditioner

// File: tb/tb_gear_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_gear_input_conditioner
// Directed bench for gear_input_conditioner with SAMPLE_DIV=4, DEBOUNCE_N=3,
// REPEAT_DELAY=5, REPEAT_RATE=2. A behavioural model predicts the three
// outputs every cycle; hand-computed pulse counts and pulse times pin it.
// Inputs change 1 time unit after the falling edge; outputs are compared on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_gear_input_conditioner;

    localparam int SAMPLE_DIV   = 4;
    localparam int DEBOUNCE_N   = 3;
    localparam int REPEAT_DELAY = 5;
    localparam int REPEAT_RATE  = 2;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic ena       = 1'b0;
    logic btn_up    = 1'b0;
    logic btn_down  = 1'b0;
    logic btn_brake = 1'b0;
    logic up_pulse, down_pulse, brake_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    gear_input_conditioner #(
        .SAMPLE_DIV   (SAMPLE_DIV),
        .DEBOUNCE_N   (DEBOUNCE_N),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_brake   (btn_brake),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse),
        .brake_level (brake_level)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------
    // Behavioural model. Index 0 up, 1 down, 2 brake.
    //   dly1/dly2 : raw pin delayed by one and two clocks
    //   lvl       : debounced level
    //   run       : consecutive strobes whose sample disagreed with lvl
    //   held      : strobes since the initial pulse of a still-permitted
    //               press, -1 when no press is being tracked
    // -----------------------------------------------------------------
    bit [2:0] dly1, dly2, lvl;
    int       run  [3];
    int       held [2];
    int       phase;
    bit       exp_up, exp_dn, exp_br;

    task automatic model_reset();
        dly1 = '0; dly2 = '0; lvl = '0; phase = 0;
        for (int i = 0; i < 3; i++) run[i] = 0;
        held[0] = -1; held[1] = -1;
        exp_up = 0; exp_dn = 0; exp_br = 0;
    endtask

    task automatic model_step();
        bit [2:0] pins, nlvl, rose;
        bit       strobe;
        bit [1:0] ok, rpt;
        pins   = {btn_brake, btn_down, btn_up};
        strobe = ena && (phase == SAMPLE_DIV - 1);
        exp_br = lvl[2];
        nlvl   = lvl;
        if (strobe) begin
            for (int i = 0; i < 3; i++) begin
                if (dly2[i] != lvl[i]) begin
                    run[i]++;
                    if (run[i] == DEBOUNCE_N) begin
                        nlvl[i] = !lvl[i];
                        run[i]  = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
        rose  = nlvl & ~lvl;
        ok[0] = nlvl[0] && !nlvl[1] && !nlvl[2];
        ok[1] = nlvl[1] && !nlvl[0];
        rpt   = '0;
`ifdef GEAR_AUTOREPEAT_EN
        for (int i = 0; i < 2; i++) begin
            if (!ok[i]) held[i] = -1;
            else if (strobe && rose[i]) held[i] = 0;
            else if (strobe && held[i] >= 0) begin
                held[i]++;
                rpt[i] = (held[i] == REPEAT_DELAY) ||
                         (held[i] > REPEAT_DELAY && (held[i] - REPEAT_DELAY) % REPEAT_RATE == 0);
            end
        end
`endif
        exp_up = ena && ((rose[0] && ok[0]) || rpt[0]);
        exp_dn = ena && ((rose[1] && ok[1]) || rpt[1]);
        lvl  = nlvl;
        dly2 = dly1;
        dly1 = pins;
        if (ena) phase = (phase + 1) % SAMPLE_DIV;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        check("up_pulse_vs_model",    up_pulse,    exp_up);
        check("down_pulse_vs_model",  down_pulse,  exp_dn);
        check("brake_level_vs_model", brake_level, exp_br);
    end

    // Pulse bookkeeping for the literal checks.
    int up_cnt = 0;
    int dn_cnt = 0;
    int up_times[$];

    initial forever begin
        @(negedge clk);
        if (up_pulse === 1'b1) begin
            up_cnt++;
            up_times.push_back(cyc);
        end
        if (down_pulse === 1'b1) dn_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        up_cnt = 0;
        dn_cnt = 0;
        up_times.delete();
    endtask

    function automatic int first_up_delta();
        return (up_times.size() == 0) ? -1 : up_times[0] - t0;
    endfunction

    // Enter reset, then release it with btn_up already high; t0 marks
    // the release so pulse times are measured in clocks from it.
    task automatic restart_with_up();
        rst_n = 1'b0;
        tick(2);
        clear_counts();
        btn_up = 1'b1;
        rst_n  = 1'b1;
        t0     = cyc;
    endtask

    initial begin
        int exp_offs[$];
        int seen;

        // ---- reset and clean press ----
        ena = 1'b1;
        tick(3);
        check("reset_up_pulse",    up_pulse,    0);
        check("reset_down_pulse",  down_pulse,  0);
        check("reset_brake_level", brake_level, 0);
        restart_with_up();
        tick(80);
        check("press_up_count",   up_cnt, 1);
        check("press_up_latency", first_up_delta(), 12);
        check("press_down_count", dn_cnt, 0);
        btn_up = 1'b0;
        tick(20);
        check("release_no_pulse", up_cnt, 1);

        // ---- bounce ----
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            btn_up = (i % 2 == 0);
            tick(4);
        end
        btn_up = 1'b0;
        tick(20);
        check("bounce_up_count", up_cnt, 0);
        btn_down = 1'b1;      // a stuck stable_up would block this
        tick(20);
        check("bounce_then_down_count", dn_cnt, 1);
        btn_down = 1'b0;
        tick(20);

        // ---- simultaneous press ----
        clear_counts();
        btn_up = 1'b1; btn_down = 1'b1;
        tick(40);
        check("simul_up_count",   up_cnt, 0);
        check("simul_down_count", dn_cnt, 0);
        btn_down = 1'b0;
        tick(24);
        check("simul_release_up_count",   up_cnt, 0);
        check("simul_release_down_count", dn_cnt, 0);
        btn_up = 1'b0;
        tick(20);

        // ---- brake ----
        clear_counts();
        btn_brake = 1'b1;
        tick(20);
        check("brake_level_set", brake_level, 1);
        btn_up = 1'b1;
        tick(20);
        check("brake_blocks_up", up_cnt, 0);
        btn_up = 1'b0;
        tick(20);
        btn_down = 1'b1;
        tick(20);
        check("brake_allows_down", dn_cnt, 1);
        check("brake_up_still_0",  up_cnt, 0);
        btn_down = 1'b0; btn_brake = 1'b0;
        tick(20);
        check("brake_level_clear", brake_level, 0);

        // ---- reset mid-debounce ----
        restart_with_up();
        tick(9);              // strobes at +4 and +8 have seen the press
        rst_n = 1'b0;
        tick(2);
        check("midrst_up_pulse",    up_pulse,    0);
        check("midrst_down_pulse",  down_pulse,  0);
        check("midrst_brake_level", brake_level, 0);
        check("midrst_no_pulse",    up_cnt,      0);
        clear_counts();
        rst_n = 1'b1;
        t0    = cyc;
        tick(30);
        check("midrst_up_count",   up_cnt, 1);
        check("midrst_up_latency", first_up_delta(), 12);
        btn_up = 1'b0;
        tick(20);

        // ---- enable dropped for 8 clk mid-count ----
        restart_with_up();
        tick(5);
        ena = 1'b0;
        tick(8);
        ena = 1'b1;
        tick(30);
        check("ena_up_count",   up_cnt, 1);
        check("ena_up_latency", first_up_delta(), 20);
        btn_up = 1'b0;
        tick(20);

        // ---- auto-repeat window: 12 strobes past debounce ----
        restart_with_up();
        tick(12 + 4 * 12);
`ifdef GEAR_AUTOREPEAT_EN
        exp_offs = '{0, 5, 7, 9, 11};
`else
        exp_offs = '{0};
`endif
        seen = 0;
        foreach (up_times[i]) if (up_times[i] - t0 <= 12 + 4 * 12) seen++;
        check("repeat_pulse_count", seen, exp_offs.size());
        foreach (exp_offs[i]) begin
            if (i < up_times.size())
                check("repeat_pulse_time", up_times[i] - t0, 12 + 4 * exp_offs[i]);
            else
                check("repeat_pulse_missing", -1, 12 + 4 * exp_offs[i]);
        end
        btn_up = 1'b0;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gear_input_conditioner
